// File: rtl/mc_defines.sv
// Shared memory-controller constants used by the read-data path.
package mc_defines;

  // Read-data FIFO geometry: 4 entries of {parity[3:0], data[31:0]}.
  localparam int MC_RD_FIFO_DEPTH = 4;
  localparam int MC_RD_FIFO_DW    = 36;

endpackage : mc_defines

// File: rtl/mc_rd_fifo.sv
// Four-entry first-word-fall-through FIFO for delayed memory read data.
// One-hot write/read pointers, flip-flop storage, and a combinational head mux.
// The head mux exists so the Wishbone read mux and the parity checker see the
// oldest word without a register stage. There are no full/empty flags: the
// controller's read sequencing keeps the FIFO from overflowing or underflowing.
module mc_rd_fifo
  import mc_defines::*;
#(
  parameter int DW    = MC_RD_FIFO_DW,
  parameter int DEPTH = MC_RD_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,   // synchronous, active-low
  input  logic          clr,   // synchronous flush, active-high
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout
);

  // Both pointers return to entry 0 on reset or flush.
  localparam logic [DEPTH-1:0] PTR_INIT = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] wp_q, wp_d;
  logic [DEPTH-1:0] rp_q, rp_d;
  logic [DW-1:0]    mem_q [DEPTH];

  // Next pointer values: rotate left one position on push/pop; the top-to-bottom
  // wrap falls out of the rotate with no special case.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (we) begin
      wp_d = {wp_q[DEPTH-2:0], wp_q[DEPTH-1]};
    end
    if (re) begin
      rp_d = {rp_q[DEPTH-2:0], rp_q[DEPTH-1]};
    end
  end

  // Pointer registers: reset beats flush, and flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q <= PTR_INIT;
      rp_q <= PTR_INIT;
    end else if (clr) begin
      wp_q <= PTR_INIT;
      rp_q <= PTR_INIT;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage: each entry loads din when the write pointer selects it.
  // Reset zeroes the entries. A flush leaves them alone, so stale words stay
  // visible until they are overwritten.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst) begin
        mem_q[gi] <= '0;
      end else if (!clr && we && wp_q[gi]) begin
        mem_q[gi] <= din;
      end
    end
  end

  // Head-of-queue mux: an AND-OR over the one-hot read pointer.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rp_q[i]) begin
        dout = dout | mem_q[i];
      end
    end
  end

endmodule : mc_rd_fifo

// File: tb/tb_mc_rd_fifo.sv
// Directed testbench for mc_rd_fifo: reset, fill/drain, simultaneous push/pop,
// wrap-around, flush and overflow, with hand-computed expected head values.
module tb_mc_rd_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [35:0] din;
  logic        we;
  logic        re;
  logic [35:0] dout;

  int checks   = 0;
  int failures = 0;

  mc_rd_fifo dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .din  (din),
    .we   (we),
    .re   (re),
    .dout (dout)
  );

  always #5 clk = ~clk;

  // Apply one clock edge with the given controls, then return the controls to idle.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [35:0] d);
    we  = w;
    re  = r;
    clr = c;
    din = d;
    @(posedge clk);
    #1;
    we  = 1'b0;
    re  = 1'b0;
    clr = 1'b0;
    din = '0;
  endtask

  // Compare the head word against the expected value, #1 after the edge.
  task automatic check(input string tag, input logic [35:0] exp);
    checks++;
    assert (dout === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, dout, exp);
    end
    $display("check %-14s dout=%h expected=%h", tag, dout, exp);
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    we  = 1'b0;
    re  = 1'b0;
    din = '0;

    // Reset: two edges with a push request that must be ignored.
    cyc(1'b1, 1'b0, 1'b0, 36'hF_FFFF_FFFF);
    cyc(1'b1, 1'b0, 1'b0, 36'hF_FFFF_FFFF);
    check("reset_dout", 36'h0);
    rst = 1'b1;
    #1;
    check("reset_rel", 36'h0);
    cyc(1'b1, 1'b0, 1'b0, 36'hF_FFFF_FFFF);
    check("reset_push", 36'hF_FFFF_FFFF);

    // Fill and drain.
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, 36'h1_0000_0001);
    check("fill1", 36'h1_0000_0001);
    cyc(1'b1, 1'b0, 1'b0, 36'h2_0000_0002);
    check("fill2", 36'h1_0000_0001);
    cyc(1'b1, 1'b0, 1'b0, 36'h4_0000_0004);
    cyc(1'b1, 1'b0, 1'b0, 36'h8_0000_0008);
    check("fill4", 36'h1_0000_0001);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("drain1", 36'h2_0000_0002);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("drain2", 36'h4_0000_0004);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("drain3", 36'h8_0000_0008);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("drain_wrap", 36'h1_0000_0001);

    // Simultaneous push/pop with one entry resident.
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, 36'hA);
    check("simul_a", 36'hA);
    cyc(1'b1, 1'b1, 1'b0, 36'hB);
    check("simul_b", 36'hB);
    cyc(1'b1, 1'b1, 1'b0, 36'hC);
    check("simul_c", 36'hC);

    // Wrap-around: six push-then-pop pairs, crossing the 1000 -> 0001 wrap.
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 36'(k));
      check($sformatf("wrap_%0d", k), 36'(k));
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    // mem now holds {5,6,3,4}; wp = rp = 0100.

    // Flush with a concurrent push that must be ignored.
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, 36'h5);
    check("flush_pre", 36'h5);
    cyc(1'b1, 1'b0, 1'b0, 36'h6);
    cyc(1'b1, 1'b0, 1'b1, 36'h7);
    check("flush_stale", 36'h5);
    cyc(1'b1, 1'b0, 1'b0, 36'h9);
    check("flush_push9", 36'h9);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("flush_mem1", 36'h6);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("flush_no7", 36'h3);

    // Overflow: five pushes, and the fifth overwrites entry 0.
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 36'(k));
    end
    check("ovf_head", 36'h5);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("ovf_next", 36'h2);

    // Pop while empty: rp still advances, exposing the stale entry.
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("empty_pop", 36'h2);

    // Reset mid-stream clears storage and pointers.
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 36'hD);
    rst = 1'b1;
    #1;
    check("reset_mid", 36'h0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("reset_mem1", 36'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mc_rd_fifo
